// File: rtl/video_mix_ctrl.sv
// video_mix_ctrl: frame-synchronous mix-mode select and output mute control.
// Mix changes are requested over a four-phase req/ack handshake and are
// applied only at the rising edge of vertical blanking. Active lines per
// frame are measured, and the output stays muted until the line count has
// been stable for MUTE_FRAMES consecutive frames.
module video_mix_ctrl #(
  parameter int unsigned MUTE_FRAMES = 2,
  parameter int unsigned LINE_W      = 12
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              HBlank,
  input  logic              VBlank,
  input  logic              req,
  input  logic [1:0]        req_mix,
  output logic              ack,
  output logic [1:0]        mix_out,
  output logic              mute,
  output logic              mode_change,
  output logic [LINE_W-1:0] lines_per_frame
);

  localparam int unsigned    MW        = (MUTE_FRAMES < 2) ? 1 : $clog2(MUTE_FRAMES + 1);
  localparam logic [MW-1:0]  MUTE_INIT = MW'(MUTE_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKW = 2'd2
  } state_t;

  logic              hb_q, vb_q;
  logic              line_ev, frame_ev, count_diff;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] lpf_q;
  logic [MW-1:0]     mute_cnt_q, mute_cnt_d;
  logic              mute_q, mc_q;

  state_t            state_q;
  logic [1:0]        pend_q, mix_q;
  logic              ack_q;

  assign line_ev    = ce_pix & HBlank & ~hb_q;
  assign frame_ev   = ce_pix & VBlank & ~vb_q;
  assign count_diff = (line_cnt_q != lpf_q);

  // Line counter next state: a line event coinciding with the frame event
  // is the first line of the new frame, hence the reload to 1.
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (frame_ev) begin
      line_cnt_d = line_ev ? LINE_W'(1) : '0;
    end else if (line_ev && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + LINE_W'(1);
    end
  end

  // Mute counter next state: reload on a line-count change, else count down.
  always_comb begin
    mute_cnt_d = mute_cnt_q;
    if (frame_ev) begin
      if (count_diff) begin
        mute_cnt_d = MUTE_INIT;
      end else if (mute_cnt_q != '0) begin
        mute_cnt_d = mute_cnt_q - MW'(1);
      end
    end
  end

  // Blanking edge history, line measurement and mute state.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      line_cnt_q <= '0;
      lpf_q      <= '0;
      mute_cnt_q <= MUTE_INIT;
      mute_q     <= 1'b1;
      mc_q       <= 1'b0;
    end else begin
      if (ce_pix) begin
        hb_q <= HBlank;
        vb_q <= VBlank;
      end
      if (frame_ev) begin
        lpf_q <= line_cnt_q;
      end
      line_cnt_q <= line_cnt_d;
      mute_cnt_q <= mute_cnt_d;
      mute_q     <= (mute_cnt_d != '0);
      mc_q       <= frame_ev & count_diff;
    end
  end

  // Request handshake: latch, wait for vertical blank, apply and ack.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mix_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            pend_q  <= req_mix;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (frame_ev) begin
            mix_q   <= pend_q;
            ack_q   <= 1'b1;
            state_q <= ACKW;
          end
        end
        ACKW: begin
          if (!req) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack             = ack_q;
  assign mix_out         = mix_q;
  assign mute            = mute_q;
  assign mode_change     = mc_q;
  assign lines_per_frame = lpf_q;

endmodule

// File: doc/video_mix_ctrl.md
# video_mix_ctrl

Frame-synchronous controller for the video cleaner's colour-mix select and output muting. It accepts mix-mode change requests from the OSD/menu side over a four-phase handshake and applies them only at the start of vertical blanking, so a frame never changes colour mode mid-scan. It also measures active lines per frame and mutes the output for a programmable number of frames after power-up or any line-count change. It sits between the menu logic and the cleaner's `mix` input, and is fed by the cleaner's aligned `HBlank_out`/`VBlank_out`.

## Interface
- `MUTE_FRAMES`, default 2: number of consecutive frames with an unchanged line count required before `mute` is released (≥1).
- `LINE_W`, default 12: width of the line counter and `lines_per_frame`.

- `clk_vid`  in  1  video clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce_pix`  in  1  pixel enable; all blanking sampling is qualified by it.
- `HBlank`  in  1  aligned horizontal blank.
- `VBlank`  in  1  aligned vertical blank.
- `req`  in  1  mix-change request level (four-phase).
- `req_mix`  in  2  requested mode: 0 colour, 1 green, 2 amber, 3 gray. Must be stable while `req`=1.
- `ack`  out  1  request applied; held until `req` falls.
- `mix_out`  out  2  mix select to the cleaner.
- `mute`  out  1  force-black request to the downstream output stage.
- `mode_change`  out  1  one-`clk_vid` pulse on a detected line-count change.
- `lines_per_frame`  out  LINE_W  line count of the last completed frame.

## Operation
- Reset values: `mix_out`=0, `ack`=0, `mute`=1, `mode_change`=0, `lines_per_frame`=0, mute counter=MUTE_FRAMES, line counter=0, `hb_d`=`vb_d`=0, FSM=IDLE.
- `hb_d` and `vb_d` are registered copies of HBlank and VBlank. They update only when `ce_pix`=1.
- Line event: `ce_pix & HBlank & ~hb_d`.
- Frame event: `ce_pix & VBlank & ~vb_d`.
- Line counter:
  - Increments on each line event and saturates at all-ones.
  - On a frame event, the current count is compared with `lines_per_frame` and then copied into it.
  - In the same cycle the counter reloads to 1 if a line event coincides, else to 0. A coincident line event therefore belongs to the new frame.
- Mute counter, evaluated only on a frame event:
  - If the count differs from `lines_per_frame`: `mode_change` pulses and the mute counter reloads to MUTE_FRAMES.
  - Else, if the mute counter is nonzero, it decrements.
  - `mute` = (mute counter != 0).
  - Because `lines_per_frame` resets to 0, the first frame with nonzero lines always registers a change.
- Request FSM:
  - IDLE: if `req`=1, latch `req_mix` into `pend_mix` and go to PEND.
  - PEND: if `req`=0, drop the request and return to IDLE with `mix_out` unchanged and no `ack`. Else, on a frame event, set `mix_out`<=`pend_mix`, `ack`<=1 and go to ACKW.
  - ACKW: hold `ack`=1. When `req`=0, clear `ack` and go to IDLE.
- Simultaneous events: a mix apply and a line-count change on the same frame event both take effect in that cycle.
- Re-requesting the current mode still waits for a frame event and still acks.
- Reset asserted mid-operation returns everything to its reset values immediately; any pending request is lost.

## Timing
- All outputs are registered. Each reacts on the `clk_vid` edge following the qualifying `ce_pix` cycle (1-cycle latency).
- Request-to-apply latency runs from `req` rising to the next frame event, plus 1 clk. Worst case is one frame plus 2 clk.
- `ack` falls 1 clk after `req` is sampled low in ACKW. A new request is accepted at the earliest 1 clk after that.
- `mode_change` is exactly 1 clk wide, independent of `ce_pix`.
- Blanking inputs that change on cycles with `ce_pix`=0 are not seen until the next `ce_pix`=1 cycle.

## Test plan
- Reset, then frames of 240 lines (HBlank pulses, ce_pix every 4th clk) -> `mode_change` pulses at the 1st frame event. `lines_per_frame`=240. `mute` falls at the 3rd frame event (MUTE_FRAMES=2). `mix_out`=0.
- With stable video, `req`=1 and `req_mix`=2 mid-frame -> `mix_out` stays 0 until the next VBlank rise, becomes 2 one clk after it, `ack`=1. Drop `req` -> `ack`=0 after 1 clk.
- `req`=1 with `req_mix`=3, dropped before the next VBlank -> no `ack`, `mix_out` unchanged. The next VBlank rise changes nothing.
- Change to 262 lines while unmuted -> at that frame event `mode_change` pulses, `lines_per_frame`=262, `mute`=1. `mute`=0 again after two more 262-line frames.
- HBlank rise coincident with VBlank rise on a ce_pix cycle -> the new frame's count starts at 1; a 240-line frame reports 240 with no spurious `mode_change`.
- Assert `reset` while in PEND and in ACKW -> `ack`=0, `mix_out`=0, `mute`=1 asynchronously. After release the FSM is IDLE and re-requests with a fresh `req` rise.
